// File: rtl/mtl_pkg.sv
// Shared timing defaults and pixel/counter types for the MTL 800x480 panel path.
package mtl_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 210;
    localparam int DEF_H_SYNC   = 30;
    localparam int DEF_H_BP     = 16;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 22;
    localparam int DEF_V_SYNC   = 13;
    localparam int DEF_V_BP     = 10;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [10:0] xcnt_t;
    typedef logic [9:0]  ycnt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/mtl_display_ctrl_pipe_delay.sv
// Generic WIDTH x DEPTH shift register with synchronous active-low clear.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = clk & reset;
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_p [DEPTH];

        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
            end else begin
                stage_p[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
            end
        end

        assign q = stage_p[DEPTH-1];
    end

endmodule

// File: rtl/mtl_display_ctrl.sv
// Raster counter generator and LCD pin register wrapped around a PIPE_LAT-deep renderer.
module mtl_display_ctrl
    import mtl_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rgb_in_r,
    input  logic [7:0]  rgb_in_g,
    input  logic [7:0]  rgb_in_b,
    output logic [10:0] x_cnt,
    output logic [9:0]  y_cnt,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  lcd_r,
    output logic [7:0]  lcd_g,
    output logic [7:0]  lcd_b,
    output logic        lcd_hsync_n,
    output logic        lcd_vsync_n,
    output logic        lcd_de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL >= 2048) begin : g_bad_h_total
        $error("mtl_display_ctrl: H_TOTAL must be below 2048");
    end
    if (V_TOTAL >= 1024) begin : g_bad_v_total
        $error("mtl_display_ctrl: V_TOTAL must be below 1024");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_pipe_lat
        $error("mtl_display_ctrl: PIPE_LAT must be in 0..7");
    end

    localparam xcnt_t X_LAST     = xcnt_t'(H_TOTAL - 1);
    localparam xcnt_t X_ACT_END  = xcnt_t'(H_ACTIVE);
    localparam xcnt_t X_HS_START = xcnt_t'(H_ACTIVE + H_FP);
    localparam xcnt_t X_HS_END   = xcnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam ycnt_t Y_LAST     = ycnt_t'(V_TOTAL - 1);
    localparam ycnt_t Y_ACT_END  = ycnt_t'(V_ACTIVE);
    localparam ycnt_t Y_VS_START = ycnt_t'(V_ACTIVE + V_FP);
    localparam ycnt_t Y_VS_END   = ycnt_t'(V_ACTIVE + V_FP + V_SYNC);

    xcnt_t      x_p0;
    ycnt_t      y_p0;
    logic [7:0] frame_p0;

    // Stage p0: raster counters; y advances only on the x wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_p0     <= '0;
            y_p0     <= '0;
            frame_p0 <= '0;
        end else if (x_p0 == X_LAST) begin
            x_p0 <= '0;
            if (y_p0 == Y_LAST) begin
                y_p0     <= '0;
                frame_p0 <= frame_p0 + 8'd1;
            end else begin
                y_p0 <= y_p0 + ycnt_t'(1);
            end
        end else begin
            x_p0 <= x_p0 + xcnt_t'(1);
        end
    end

    assign x_cnt       = x_p0;
    assign y_cnt       = y_p0;
    assign frame_cnt   = frame_p0;
    assign frame_start = (x_p0 == '0) && (y_p0 == '0);

    logic       de_raw_p0;
    logic       hs_raw_p0;
    logic       vs_raw_p0;
    logic [2:0] timing_p0;
    logic [2:0] timing_pd;

    assign de_raw_p0 = (x_p0 < X_ACT_END) && (y_p0 < Y_ACT_END);
    assign hs_raw_p0 = (x_p0 >= X_HS_START) && (x_p0 < X_HS_END);
    assign vs_raw_p0 = (y_p0 >= Y_VS_START) && (y_p0 < Y_VS_END);
    assign timing_p0 = {de_raw_p0, hs_raw_p0, vs_raw_p0};

    // Stages p1..pN: align DE/sync with the renderer's RGB latency
    pipe_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_timing_delay (
        .clk   (clk),
        .reset (reset),
        .d     (timing_p0),
        .q     (timing_pd)
    );

    logic de_pd;
    logic hs_pd;
    logic vs_pd;
    rgb_t rgb_in;
    rgb_t rgb_out;

    assign {de_pd, hs_pd, vs_pd} = timing_pd;
    assign rgb_in = {rgb_in_r, rgb_in_g, rgb_in_b};

    // Output stage: pin register, RGB blanked wherever DE is low
    always_ff @(posedge clk) begin
        if (!reset) begin
            lcd_de      <= 1'b0;
            lcd_hsync_n <= 1'b1;
            lcd_vsync_n <= 1'b1;
            rgb_out     <= '0;
        end else begin
            lcd_de      <= de_pd;
            lcd_hsync_n <= ~hs_pd;
            lcd_vsync_n <= ~vs_pd;
            rgb_out     <= de_pd ? rgb_in : '0;
        end
    end

    assign lcd_r = rgb_out.r;
    assign lcd_g = rgb_out.g;
    assign lcd_b = rgb_out.b;

endmodule

// File: tb/tb_mtl_display_ctrl.sv
// Scoreboard bench: three instances (full-size PIPE_LAT=2, small raster PIPE_LAT=0 and 7).
module tb_mtl_display_ctrl;

    // k: 0 HA, 1 HF, 2 HS, 3 HB, 4 VA, 5 VF, 6 VS, 7 VB, 8 PIPE_LAT
    function automatic int tim(input int g, input int k);
        case (k)
            0: return (g == 0) ? 800 : 10;
            1: return (g == 0) ? 210 : 3;
            2: return (g == 0) ? 30  : 2;
            3: return (g == 0) ? 16  : 1;
            4: return (g == 0) ? 480 : 5;
            5: return (g == 0) ? 22  : 2;
            6: return (g == 0) ? 13  : 2;
            7: return (g == 0) ? 10  : 1;
            8: return (g == 0) ? 2 : ((g == 1) ? 0 : 7);
            default: return 0;
        endcase
    endfunction

    function automatic int ht(input int g);
        return tim(g, 0) + tim(g, 1) + tim(g, 2) + tim(g, 3);
    endfunction

    function automatic int vt(input int g);
        return tim(g, 4) + tim(g, 5) + tim(g, 6) + tim(g, 7);
    endfunction

    // Raster position of the n-th cycle after reset, by plain division
    function automatic void pos(input int g, input int n, output int x, output int y, output int f);
        x = n % ht(g);
        y = (n / ht(g)) % vt(g);
        f = (n / (ht(g) * vt(g))) % 256;
    endfunction

    typedef struct {
        int         cyc;
        logic [10:0] x;
        logic [9:0]  y;
        logic        fs;
        logic [7:0]  fc;
        logic        de;
        logic        hs_n;
        logic        vs_n;
        logic [7:0]  er;
        logic [7:0]  eg;
        logic [7:0]  eb;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  rin_r [3];
    logic [7:0]  rin_g [3];
    logic [7:0]  rin_b [3];
    logic [10:0] x_o   [3];
    logic [9:0]  y_o   [3];
    logic        fs_o  [3];
    logic [7:0]  fc_o  [3];
    logic [7:0]  r_o   [3];
    logic [7:0]  g_o   [3];
    logic [7:0]  b_o   [3];
    logic        hs_o  [3];
    logic        vs_o  [3];
    logic        de_o  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mtl_display_ctrl #(
            .H_ACTIVE (tim(gi, 0)),
            .H_FP     (tim(gi, 1)),
            .H_SYNC   (tim(gi, 2)),
            .H_BP     (tim(gi, 3)),
            .V_ACTIVE (tim(gi, 4)),
            .V_FP     (tim(gi, 5)),
            .V_SYNC   (tim(gi, 6)),
            .V_BP     (tim(gi, 7)),
            .PIPE_LAT (tim(gi, 8))
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .rgb_in_r    (rin_r[gi]),
            .rgb_in_g    (rin_g[gi]),
            .rgb_in_b    (rin_b[gi]),
            .x_cnt       (x_o[gi]),
            .y_cnt       (y_o[gi]),
            .frame_start (fs_o[gi]),
            .frame_cnt   (fc_o[gi]),
            .lcd_r       (r_o[gi]),
            .lcd_g       (g_o[gi]),
            .lcd_b       (b_o[gi]),
            .lcd_hsync_n (hs_o[gi]),
            .lcd_vsync_n (vs_o[gi]),
            .lcd_de      (de_o[gi])
        );
    end

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    bit   pat_mode = 1'b1;
    bit   agg_en = 1'b0;
    bit   done = 1'b0;
    bit   mon_done = 1'b0;
    exp_t exp_q [3][$];

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of stimulus and queue what every instance must show next cycle
    task automatic step(input logic rst_v);
        int   nn, lat, x, y, f, px, py, pf;
        logic de, hs, vs;
        logic [7:0] r, gg, b;
        exp_t e;
        reset = rst_v;
        nn = rst_v ? n + 1 : 0;
        for (int g = 0; g < 3; g++) begin
            lat = tim(g, 8);
            if (pat_mode && n >= lat) begin
                pos(g, n - lat, px, py, pf);
                r = px[7:0];
                gg = py[7:0];
                b = 8'hA5;
            end else begin
                {r, gg, b} = 24'($urandom);
            end
            rin_r[g] = r;
            rin_g[g] = gg;
            rin_b[g] = b;

            e.cyc = cyc + 1;
            pos(g, nn, x, y, f);
            e.x  = 11'(x);
            e.y  = 10'(y);
            e.fc = 8'(f);
            e.fs = (x == 0) && (y == 0);
            if (rst_v && nn >= lat + 1) begin
                pos(g, nn - lat - 1, px, py, pf);
                de = (px < tim(g, 0)) && (py < tim(g, 4));
                hs = (px >= tim(g, 0) + tim(g, 1)) && (px < tim(g, 0) + tim(g, 1) + tim(g, 2));
                vs = (py >= tim(g, 4) + tim(g, 5)) && (py < tim(g, 4) + tim(g, 5) + tim(g, 6));
            end else begin
                de = 1'b0;
                hs = 1'b0;
                vs = 1'b0;
            end
            e.de   = de;
            e.hs_n = ~hs;
            e.vs_n = ~vs;
            e.er   = de ? r  : 8'h00;
            e.eg   = de ? gg : 8'h00;
            e.eb   = de ? b  : 8'h00;
            exp_q[g].push_back(e);
        end
        n = nn;
        @(posedge clk);
        #1;
    endtask

    int         de_run [3] = '{0, 0, 0};
    int         hs_run [3] = '{0, 0, 0};
    int         vs_run [3] = '{0, 0, 0};
    logic [7:0] fc_prev [3] = '{8'd0, 8'd0, 8'd0};
    bit         wrapped [3] = '{1'b0, 1'b0, 1'b0};
    int         xh [3][$];

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            exp_t e;
            int   lat;
            int   back;
            lat = tim(g, 8);
            while (exp_q[g].size() > 0 && exp_q[g][0].cyc < cyc) begin
                e = exp_q[g].pop_front();
                checks++;
                errors++;
                $display("FAIL sb_stale[%0d]: entry for cycle %0d never compared (now %0d)", g, e.cyc, cyc);
            end
            if (exp_q[g].size() > 0 && exp_q[g][0].cyc == cyc) begin
                e = exp_q[g].pop_front();
                checks++;
                if (x_o[g] !== e.x || y_o[g] !== e.y || fs_o[g] !== e.fs || fc_o[g] !== e.fc ||
                    de_o[g] !== e.de || hs_o[g] !== e.hs_n || vs_o[g] !== e.vs_n ||
                    r_o[g] !== e.er || g_o[g] !== e.eg || b_o[g] !== e.eb) begin
                    errors++;
                    $display("FAIL pins[%0d] cyc=%0d got x=%0d y=%0d fs=%0b fc=%0d de=%0b hs_n=%0b vs_n=%0b rgb=%h_%h_%h expected x=%0d y=%0d fs=%0b fc=%0d de=%0b hs_n=%0b vs_n=%0b rgb=%h_%h_%h",
                             g, cyc, x_o[g], y_o[g], fs_o[g], fc_o[g], de_o[g], hs_o[g], vs_o[g], r_o[g], g_o[g], b_o[g],
                             e.x, e.y, e.fs, e.fc, e.de, e.hs_n, e.vs_n, e.er, e.eg, e.eb);
                end
            end

            xh[g].push_back(int'(x_o[g]));
            if (xh[g].size() > 10) void'(xh[g].pop_front());

            if (agg_en) begin
                if (de_o[g] === 1'b1) de_run[g]++;
                else if (de_run[g] > 0) begin
                    checks++;
                    if (de_run[g] != tim(g, 0)) begin
                        errors++;
                        $display("FAIL de_run[%0d]: got %0d clocks, expected %0d", g, de_run[g], tim(g, 0));
                    end
                    de_run[g] = 0;
                end

                if (hs_o[g] === 1'b0) begin
                    if (hs_run[g] == 0 && xh[g].size() >= lat + 2) begin
                        back = xh[g][xh[g].size() - 2 - lat];
                        checks++;
                        if (back != tim(g, 0) + tim(g, 1)) begin
                            errors++;
                            $display("FAIL hs_offset[%0d]: x_cnt %0d clocks earlier was %0d, expected %0d",
                                     g, lat + 1, back, tim(g, 0) + tim(g, 1));
                        end
                    end
                    hs_run[g]++;
                end else if (hs_run[g] > 0) begin
                    checks++;
                    if (hs_run[g] != tim(g, 2)) begin
                        errors++;
                        $display("FAIL hs_run[%0d]: got %0d clocks, expected %0d", g, hs_run[g], tim(g, 2));
                    end
                    hs_run[g] = 0;
                end

                if (vs_o[g] === 1'b0) vs_run[g]++;
                else if (vs_run[g] > 0) begin
                    checks++;
                    if (vs_run[g] != tim(g, 6) * ht(g)) begin
                        errors++;
                        $display("FAIL vs_run[%0d]: got %0d clocks, expected %0d", g, vs_run[g], tim(g, 6) * ht(g));
                    end
                    vs_run[g] = 0;
                end
            end else begin
                de_run[g] = 0;
                hs_run[g] = 0;
                vs_run[g] = 0;
            end

            if (fc_prev[g] == 8'd255 && fc_o[g] == 8'd0) wrapped[g] = 1'b1;
            fc_prev[g] = fc_o[g];
        end

        if (done && !mon_done) begin
            for (int g = 1; g < 3; g++) begin
                checks++;
                if (!wrapped[g]) begin
                    errors++;
                    $display("FAIL frame_wrap[%0d]: got no 255->0 transition, expected one", g);
                end
            end
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (exp_q[g].size() != 0) begin
                    errors++;
                    $display("FAIL sb_drain[%0d]: got %0d pending entries, expected 0", g, exp_q[g].size());
                end
            end
            mon_done = 1'b1;
        end
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            rin_r[g] = 8'h00;
            rin_g[g] = 8'h00;
            rin_b[g] = 8'h00;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) step(1'b0);
        // Full-size raster sits at x=500, y=3 when the one-clock reset lands
        repeat (3 * 1056 + 500) step(1'b1);
        step(1'b0);
        agg_en = 1'b1;
        repeat (20000) step(1'b1);
        pat_mode = 1'b0;
        repeat (21300) step(1'b1);
        done = 1'b1;
        for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            checks++;
            errors++;
            $display("FAIL monitor_done: got no final check within 20 clocks, expected completion");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtl_display_ctrl.md
Name: mtl_display_ctrl

Overview:
- Upstream and downstream bracket for the MTL 800x480 pixel renderers, such as the cube renderer.
- Generates the raster counters x_cnt/y_cnt that feed the renderers.
- Delays panel sync and data-enable to match the renderer's pipeline latency.
- Registers the renderer's RGB, blanked outside the active area, onto the LCD pins.
- Sits between the pixel-clock domain top level and the panel connector.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 210, horizontal front porch (clocks)
H_SYNC, 30, hsync pulse width
H_BP, 16, horizontal back porch; H_TOTAL = 1056
V_ACTIVE, 480, visible lines
V_FP, 22, vertical front porch (lines)
V_SYNC, 13, vsync pulse width
V_BP, 10, vertical back porch; V_TOTAL = 525
PIPE_LAT, 2, clocks from x_cnt/y_cnt to valid renderer RGB; range 0..7

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-low reset
rgb_in_r  in  8  renderer red, valid PIPE_LAT clocks after its x_cnt/y_cnt
rgb_in_g  in  8  renderer green
rgb_in_b  in  8  renderer blue
x_cnt  out  11  horizontal counter, 0..H_TOTAL-1, registered
y_cnt  out  10  vertical counter, 0..V_TOTAL-1, registered
frame_start  out  1  high for the single clock where x_cnt==0 && y_cnt==0
frame_cnt  out  8  completed-frame counter
lcd_r, lcd_g, lcd_b  out  8 each  panel RGB
lcd_hsync_n  out  1  active-low hsync
lcd_vsync_n  out  1  active-low vsync
lcd_de  out  1  data enable

Behaviour:
- Line order: active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. Frame order is the same, counted in lines.
- x_cnt increments every clock and wraps H_TOTAL-1 -> 0.
- y_cnt increments only on an x wrap; when y_cnt == V_TOTAL-1 it wraps to 0.
- frame_cnt increments on the combined x/y wrap and wraps 255 -> 0.
- frame_start is a decode of the registered counters (x==0, y==0), so it is high in the first cycle after reset release.
- Raw timing computed from the counters in cycle t:
  - de_raw = (x_cnt < H_ACTIVE) && (y_cnt < V_ACTIVE)
  - hs_raw = x in the hsync window
  - vs_raw = y in the vsync window, for the whole line
- de_raw/hs_raw/vs_raw pass through a PIPE_LAT-deep shift register. At depth 0 the shift register is a wire.
- Output register, updated every clock:
  - lcd_de <= de_d
  - lcd_hsync_n <= ~hs_d
  - lcd_vsync_n <= ~vs_d
  - lcd_rgb <= de_d ? rgb_in : 0
- End-to-end latency: counters at t -> pins at t+PIPE_LAT+1. RGB sampled at t+PIPE_LAT aligns with its pixel's DE.
- Reset (reset==0 at a clk edge) takes priority over everything:
  - x_cnt, y_cnt, frame_cnt = 0
  - all delay-line stages = 0
  - lcd_de = 0, lcd_rgb = 0
  - lcd_hsync_n = lcd_vsync_n = 1
- Reset asserted mid-frame: the raster restarts at (0,0) in the first cycle after release. No partial sync pulse beyond the reset edge.
- rgb_in outside DE is ignored (forced 0).
- Illegal parameter combinations: elaboration-time assertion that H_TOTAL < 2048 and V_TOTAL < 1024.

Decomposition:
- Package mtl_pkg holds:
  - default timing constants (H_*/V_* and derived H_TOTAL/V_TOTAL)
  - typedef rgb_t (packed struct r,g,b, 8 bits each)
  - typedefs xcnt_t (logic [10:0]) and ycnt_t (logic [9:0])
- One sub-module, pipe_delay: parameterised WIDTH/DEPTH shift register with synchronous active-low clear. It is used here for the 3-bit sync/DE bundle and is reusable by other renderers.

Test Plan:
- Reset held 5 clocks, released -> x_cnt=0, y_cnt=0, frame_start=1, lcd_hsync_n=1, lcd_vsync_n=1, lcd_de=0 in the first post-release cycle; x_cnt=1 next cycle.
- Free run 1056 clocks -> x_cnt wraps 1055->0, y_cnt 0->1. lcd_hsync_n low for exactly 30 clocks, first low when counter x=1010 is presented at the pins, i.e. PIPE_LAT+1=3 clocks later.
- Free run 525x1056 clocks -> y_cnt wraps 524->0, frame_cnt 0->1, frame_start one pulse. lcd_vsync_n low for 13x1056 clocks. lcd_de high count per frame = 384000.
- rgb_in driven as {x[7:0], y[7:0], 8'hA5}, delayed by PIPE_LAT -> at the pin cycle of pixel (400,200), lcd_r=0x90, lcd_g=0xC8, lcd_b=0xA5. Pixel (800,0) and any porch pixel -> RGB 0.
- Assert reset at x=500, y=300 for 1 clock -> next cycle pins idle/blanked, counters restart (0,0), frame_cnt=0.
- Rerun the timing checks with PIPE_LAT=0 and 7 -> DE/sync offset from counters equals 1 and 8 clocks respectively; run 256 frames -> frame_cnt wraps 255->0.
